// File: rtl/image_rom_arbiter.sv
// rtl/image_rom_arbiter.sv - shares the image ROM between the real-time display and a host port through a tagged 3-stage read pipeline.
// Optional feature macro: IMG_ARB_BORDER_EN (off-image active pixels return BORDER_COLOR).
module image_rom_arbiter #(
   parameter int          IMAGE_WIDTH  = 640,
   parameter int          IMAGE_HEIGHT = 480,
   parameter int          ADDR_WIDTH   = 19,
   parameter logic [11:0] BORDER_COLOR = 12'h000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  pixel_tick,
   input  logic                  video_on,
   input  logic [9:0]            pixel_x,
   input  logic [9:0]            pixel_y,
   output logic [11:0]           disp_rgb,
   input  logic                  host_req,
   input  logic [ADDR_WIDTH-1:0] host_addr,
   output logic                  host_ack,
   output logic [11:0]           host_rdata,
   output logic                  host_rvalid,
   output logic                  rom_en,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   input  logic [11:0]           rom_data
);

   localparam logic [2:0] TAG_NONE       = 3'd0;
   localparam logic [2:0] TAG_DISP       = 3'd1;
   localparam logic [2:0] TAG_DISP_BLANK = 3'd2;
   localparam logic [2:0] TAG_HOST       = 3'd3;
   localparam logic [2:0] TAG_HOST_OOR   = 3'd4;

   localparam logic [9:0]            X_LIMIT    = 10'(IMAGE_WIDTH);
   localparam logic [9:0]            Y_LIMIT    = 10'(IMAGE_HEIGHT);
   localparam logic [ADDR_WIDTH-1:0] HOST_LIMIT = ADDR_WIDTH'(IMAGE_WIDTH * IMAGE_HEIGHT);

   logic [2:0]            w_issue_tag;
   logic [ADDR_WIDTH-1:0] w_issue_addr;
   logic [ADDR_WIDTH-1:0] w_disp_addr;
   logic                  w_in_image;
   logic                  w_host_busy;
   logic                  w_host_ack;
   logic                  w_border_sel;

   logic [2:0]            r_rom_tag;
   logic [2:0]            r_ret_tag;
   logic                  r_rom_en;
   logic [ADDR_WIDTH-1:0] r_rom_addr;
   logic [11:0]           r_disp_rgb;
   logic [11:0]           r_host_rdata;
   logic                  r_host_rvalid;

   // y*640 + x without a multiplier: 640 = 512 + 128
   assign w_disp_addr = (ADDR_WIDTH'(pixel_y) << 9) + (ADDR_WIDTH'(pixel_y) << 7) + ADDR_WIDTH'(pixel_x);
   assign w_in_image  = video_on && (pixel_x < X_LIMIT) && (pixel_y < Y_LIMIT);
   assign w_host_busy = (r_rom_tag == TAG_HOST) || (r_rom_tag == TAG_HOST_OOR) ||
                        (r_ret_tag == TAG_HOST) || (r_ret_tag == TAG_HOST_OOR);

   always_comb begin
      w_issue_tag  = TAG_NONE;
      w_issue_addr = host_addr;
      w_host_ack   = 1'b0;
      if (pixel_tick) begin
         w_issue_addr = w_disp_addr;
         w_issue_tag  = w_in_image ? TAG_DISP : TAG_DISP_BLANK;
      end else if (host_req && !w_host_busy) begin
         w_host_ack  = 1'b1;
         w_issue_tag = (host_addr >= HOST_LIMIT) ? TAG_HOST_OOR : TAG_HOST;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rom_tag  <= TAG_NONE;
         r_ret_tag  <= TAG_NONE;
         r_rom_en   <= 1'b0;
         r_rom_addr <= '0;
      end else begin
         r_rom_tag <= w_issue_tag;
         r_ret_tag <= r_rom_tag;
         r_rom_en  <= (w_issue_tag == TAG_DISP) || (w_issue_tag == TAG_HOST);
         if ((w_issue_tag == TAG_DISP) || (w_issue_tag == TAG_HOST))
            r_rom_addr <= w_issue_addr;
      end
   end

`ifdef IMG_ARB_BORDER_EN
   logic r_rom_border;
   logic r_ret_border;

   // Only consulted for DISP_BLANK, where video_on alone separates border from blanking
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rom_border <= 1'b0;
         r_ret_border <= 1'b0;
      end else begin
         r_rom_border <= pixel_tick && video_on;
         r_ret_border <= r_rom_border;
      end
   end

   assign w_border_sel = r_ret_border;
`else
   assign w_border_sel = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_disp_rgb    <= 12'h000;
         r_host_rdata  <= 12'h000;
         r_host_rvalid <= 1'b0;
      end else begin
         r_host_rvalid <= 1'b0;
         case (r_ret_tag)
            TAG_DISP:       r_disp_rgb <= rom_data;
            TAG_DISP_BLANK: r_disp_rgb <= w_border_sel ? BORDER_COLOR : 12'h000;
            TAG_HOST: begin
               r_host_rdata  <= rom_data;
               r_host_rvalid <= 1'b1;
            end
            TAG_HOST_OOR: begin
               r_host_rdata  <= 12'h000;
               r_host_rvalid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign host_ack    = w_host_ack && !reset;
   assign rom_en      = r_rom_en;
   assign rom_addr    = r_rom_addr;
   assign disp_rgb    = r_disp_rgb;
   assign host_rdata  = r_host_rdata;
   assign host_rvalid = r_host_rvalid;

endmodule

// File: tb/tb_image_rom_arbiter.sv
// tb/tb_image_rom_arbiter.sv - scoreboard bench for image_rom_arbiter with a frame-level reference model.
module tb_image_rom_arbiter;

   localparam logic [11:0] BORDER = 12'hABC;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        pixel_tick = 1'b0;
   logic        video_on = 1'b0;
   logic [9:0]  pixel_x = '0;
   logic [9:0]  pixel_y = '0;
   logic        host_req = 1'b0;
   logic [18:0] host_addr = '0;
   logic [11:0] rom_data = '0;
   logic [11:0] disp_rgb;
   logic        host_ack;
   logic [11:0] host_rdata;
   logic        host_rvalid;
   logic        rom_en;
   logic [18:0] rom_addr;

   image_rom_arbiter #(.BORDER_COLOR(BORDER)) dut (
      .clk(clk), .reset(reset), .pixel_tick(pixel_tick), .video_on(video_on),
      .pixel_x(pixel_x), .pixel_y(pixel_y), .disp_rgb(disp_rgb),
      .host_req(host_req), .host_addr(host_addr), .host_ack(host_ack),
      .host_rdata(host_rdata), .host_rvalid(host_rvalid),
      .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [11:0] rom_fn(input logic [18:0] a);
      return a[11:0] ^ {5'b0, a[18:12]};
   endfunction

   always @(posedge clk) if (rom_en) rom_data <= rom_fn(rom_addr);

   int total = 0;
   int bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   typedef struct {
      int          c;
      logic [11:0] d;
   } exp_t;

   exp_t        disp_q[$];
   exp_t        host_q[$];
   bit          rom_v[int];
   logic [18:0] rom_a[int];

   function automatic logic [11:0] blank_color(input bit von);
`ifdef IMG_ARB_BORDER_EN
      return von ? BORDER : 12'h000;
`else
      return 12'h000;
`endif
   endfunction

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Display reference: linear address by plain multiplication, bounds from the image size
   task automatic tick(input int x, input int y, input bit von);
      int a;
      bit inb;
      a   = y * 640 + x;
      inb = von && (x < 640) && (y < 480);
      pixel_x    = x[9:0];
      pixel_y    = y[9:0];
      video_on   = von;
      pixel_tick = 1'b1;
      rom_v[cyc + 1] = inb;
      rom_a[cyc + 1] = a[18:0];
      disp_q.push_back('{c: cyc + 3, d: inb ? rom_fn(a[18:0]) : blank_color(von)});
      @(posedge clk);
      #1;
      pixel_tick = 1'b0;
   endtask

   task automatic push_host(input logic [18:0] a);
      bit oor;
      oor = (a >= 19'd307200);
      rom_v[cyc + 1] = !oor;
      rom_a[cyc + 1] = a;
      host_q.push_back('{c: cyc + 3, d: oor ? 12'h000 : rom_fn(a)});
   endtask

   task automatic host_read(input logic [18:0] a, output int waited);
      bit got;
      bit seen;
      got = 0;
      seen = 0;
      waited = 0;
      host_req  = 1'b1;
      host_addr = a;
      for (int i = 0; i < 4 && !got; i++) begin
         @(negedge clk);
         if (host_ack === 1'b1) begin
            got = 1;
            push_host(a);
         end else begin
            waited++;
         end
         @(posedge clk);
         #1;
      end
      host_req = 1'b0;
      chk("host_ack_wait_le2", 32'(waited <= 2), 32'd1);
      if (got) begin
         for (int i = 0; i < 6 && !seen; i++) begin
            @(negedge clk);
            if (host_rvalid === 1'b1) seen = 1;
            @(posedge clk);
            #1;
         end
         chk("host_rvalid_seen", 32'(seen), 32'd1);
      end
   endtask

   logic [11:0] disp_m = '0;
   logic [11:0] host_m = '0;
   logic [18:0] raddr_m = '0;
   bit          rst_seen = 0;
   int          flush_keys[$];

   always @(negedge clk) begin
      if (rst_seen) begin
         disp_m  = '0;
         host_m  = '0;
         raddr_m = '0;
      end
      if (rom_v.exists(cyc)) begin
         chk("rom_en", 32'(rom_en), 32'(rom_v[cyc]));
         if (rom_v[cyc]) raddr_m = rom_a[cyc];
         rom_v.delete(cyc);
         rom_a.delete(cyc);
      end else begin
         chk("rom_en_idle", 32'(rom_en), 32'd0);
      end
      chk("rom_addr", 32'(rom_addr), 32'(raddr_m));
      if (disp_q.size() > 0 && disp_q[0].c == cyc) disp_m = disp_q.pop_front().d;
      chk("disp_rgb", 32'(disp_rgb), 32'(disp_m));
      if (host_q.size() > 0 && host_q[0].c == cyc) begin
         chk("host_rvalid", 32'(host_rvalid), 32'd1);
         host_m = host_q.pop_front().d;
      end else begin
         chk("host_rvalid_idle", 32'(host_rvalid), 32'd0);
      end
      chk("host_rdata", 32'(host_rdata), 32'(host_m));
      if (reset) begin
         chk("host_ack_in_reset", 32'(host_ack), 32'd0);
         while (disp_q.size() > 0 && disp_q[$].c > cyc) void'(disp_q.pop_back());
         while (host_q.size() > 0 && host_q[$].c > cyc) void'(host_q.pop_back());
         flush_keys.delete();
         foreach (rom_v[k]) if (k > cyc) flush_keys.push_back(k);
         foreach (flush_keys[i]) begin
            rom_v.delete(flush_keys[i]);
            rom_a.delete(flush_keys[i]);
         end
      end
      rst_seen = reset;
   end

   bit frame_done = 0;

   initial begin
      int w;
      bit got;
      int rows[5] = '{0, 1, 479, 480, 524};

      idle(3);
      @(negedge clk);
      chk("reset_disp_rgb", 32'(disp_rgb), 32'd0);
      chk("reset_host_rdata", 32'(host_rdata), 32'd0);
      chk("reset_host_ack", 32'(host_ack), 32'd0);
      chk("reset_host_rvalid", 32'(host_rvalid), 32'd0);
      chk("reset_rom_en", 32'(rom_en), 32'd0);
      chk("reset_rom_addr", 32'(rom_addr), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      idle(2);

      tick(639, 479, 1'b1);
      @(negedge clk);
      chk("last_pixel_addr", 32'(rom_addr), 32'd307199);
      @(posedge clk);
      #1;
      idle(2);
      tick(640, 0, 1'b1);
      idle(2);
      @(negedge clk);
      chk("x640_blank", 32'(disp_rgb), 32'(blank_color(1'b1)));
      @(posedge clk);
      #1;
      tick(5, 5, 1'b0);
      idle(3);

      host_read(19'd307200, w);
      chk("host_oor_rdata", 32'(host_rdata), 32'd0);

      tick(3, 2, 1'b1);
      @(negedge clk);
      chk("tick_rom_en", 32'(rom_en), 32'd1);
      chk("tick_rom_addr", 32'(rom_addr), 32'd1283);
      @(negedge clk);
      @(negedge clk);
      chk("tick_disp_rgb", 32'(disp_rgb), 32'h503);
      @(posedge clk);
      #1;

      fork
         tick(3, 2, 1'b1);
         host_read(19'd5, w);
      join
      chk("tick_blocks_host_wait", 32'(w), 32'd1);
      chk("host_addr5_rdata", 32'(host_rdata), 32'h005);
      idle(3);

      got = 0;
      host_req  = 1'b1;
      host_addr = 19'd4660;
      for (int i = 0; i < 4 && !got; i++) begin
         @(negedge clk);
         if (host_ack === 1'b1) begin
            got = 1;
            push_host(19'd4660);
         end
         @(posedge clk);
         #1;
      end
      host_req = 1'b0;
      reset    = 1'b1;
      chk("pre_reset_ack", 32'(got), 32'd1);
      @(negedge clk);
      @(negedge clk);
      chk("midreset_disp_rgb", 32'(disp_rgb), 32'd0);
      chk("midreset_host_rdata", 32'(host_rdata), 32'd0);
      chk("midreset_rom_en", 32'(rom_en), 32'd0);
      chk("midreset_rom_addr", 32'(rom_addr), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      idle(4);
      host_read(19'd4660, w);
      chk("rerequest_rdata", 32'(host_rdata), 32'(rom_fn(19'd4660)));

      fork
         begin
            foreach (rows[r]) begin
               for (int x = 0; x < 800; x++) begin
                  bit von;
                  von = (x < 640) && (rows[r] < 480);
                  if ($urandom_range(0, 15) == 0) von = !von;
                  tick(x, rows[r], von);
                  idle($urandom_range(3, 5));
               end
            end
            frame_done = 1;
         end
         begin
            while (!frame_done) begin
               logic [18:0] a;
               if ($urandom_range(0, 15) == 0) a = 19'(307200 + $urandom_range(0, 200000));
               else a = 19'($urandom_range(0, 307199));
               host_read(a, w);
            end
         end
      join

      idle(10);
      chk("disp_queue_drained", 32'(disp_q.size()), 32'd0);
      chk("host_queue_drained", 32'(host_q.size()), 32'd0);
      chk("rom_queue_drained", 32'(rom_v.num()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
